// File: rtl/input_unit_if.sv
// Key-entry and result signals between the keypad front end and the input_unit.
interface input_unit_if;
    logic [3:0]  key_digit;
    logic        key_press;
    logic        key_neg;
    logic        key_clear;
    logic        key_enter;
    logic [7:0]  value;
    logic        value_valid;
    logic [15:0] BCD_O;
    logic        err;

    modport master (
        output key_digit, key_press, key_neg, key_clear, key_enter,
        input  value, value_valid, BCD_O, err
    );

    modport slave (
        input  key_digit, key_press, key_neg, key_clear, key_enter,
        output value, value_valid, BCD_O, err
    );
endinterface

// File: rtl/input_unit.sv
// Calculator operand entry: decimal key events accumulate into an 8-bit two's-complement
// operand, shown as sign + 3 BCD digits, committed with a one-cycle valid strobe on enter.
module input_unit (
    input  logic         clk,
    input  logic         reset,
    input_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_DONE} state_t;

    function automatic logic signed [7:0] apply_sign(input logic [7:0] mag, input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [15:0] to_bcd(input logic [7:0] mag, input logic neg);
        logic [7:0] rem;
        logic [3:0] hund, tens, ones, sgn;
        rem  = mag;
        hund = 4'd0;
        if (rem >= 8'd100) begin
            hund = 4'd1;
            rem  = rem - 8'd100;
        end
        tens = 4'(rem / 8'd10);
        ones = 4'(rem % 8'd10);
        sgn  = (neg && (mag != 8'd0)) ? 4'hA : 4'hF;
        return {sgn, hund, tens, ones};
    endfunction

    // key level order in the vectors below: {clear, enter, neg, press}
    logic [3:0] r_lvl_p0, r_lvl_d_p0, r_dig_p0;
    logic [3:0] w_edge_p0;
    logic       r_clr_p1, r_ent_p1, r_neg_p1, r_digv_p1;
    logic [3:0] r_dig_p1;

    state_t            r_state, w_state_nx;
    logic [7:0]        r_mag, w_mag_nx;
    logic              r_neg, w_neg_nx;
    logic [1:0]        r_ndig, w_ndig_nx;
    logic              r_err, w_err_nx;
    logic signed [7:0] r_value, w_value_nx;
    logic              r_vld_p2, w_vld_nx;
    logic [9:0]        w_mag_new;
    logic [9:0]        w_mag_lim;

    // stage p0: register key levels once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl_p0   <= 4'd0;
            r_lvl_d_p0 <= 4'd0;
        end else begin
            r_lvl_p0   <= {bus.key_clear, bus.key_enter, bus.key_neg, bus.key_press};
            r_lvl_d_p0 <= r_lvl_p0;
        end
        r_dig_p0 <= bus.key_digit;
    end

    assign w_edge_p0 = r_lvl_p0 & ~r_lvl_d_p0;

    // stage p1: priority-resolved event, at most one per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_p1  <= 1'b0;
            r_ent_p1  <= 1'b0;
            r_neg_p1  <= 1'b0;
            r_digv_p1 <= 1'b0;
        end else begin
            r_clr_p1  <= w_edge_p0[3];
            r_ent_p1  <= w_edge_p0[2] & ~w_edge_p0[3];
            r_neg_p1  <= w_edge_p0[1] & ~(|w_edge_p0[3:2]);
            r_digv_p1 <= w_edge_p0[0] & ~(|w_edge_p0[3:1]);
        end
        r_dig_p1 <= r_dig_p0;
    end

    // stage p2: entry state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_EMPTY;
            r_mag    <= 8'd0;
            r_neg    <= 1'b0;
            r_ndig   <= 2'd0;
            r_err    <= 1'b0;
            r_value  <= 8'sd0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_mag    <= w_mag_nx;
            r_neg    <= w_neg_nx;
            r_ndig   <= w_ndig_nx;
            r_err    <= w_err_nx;
            r_value  <= w_value_nx;
            r_vld_p2 <= w_vld_nx;
        end
    end

    // mag <= 99 whenever ndig < 3, so 10 bits never overflow for an accepted digit
    assign w_mag_new = {2'b00, r_mag} * 10'd10 + {6'd0, r_dig_p1};
    assign w_mag_lim = r_neg ? 10'd128 : 10'd127;

    always_comb begin
        w_state_nx = r_state;
        w_mag_nx   = r_mag;
        w_neg_nx   = r_neg;
        w_ndig_nx  = r_ndig;
        w_err_nx   = r_err;
        w_value_nx = r_value;
        w_vld_nx   = 1'b0;
        if (r_clr_p1) begin
            w_state_nx = S_EMPTY;
            w_mag_nx   = 8'd0;
            w_neg_nx   = 1'b0;
            w_ndig_nx  = 2'd0;
            w_err_nx   = 1'b0;
        end else if (r_ent_p1) begin
            w_vld_nx   = 1'b1;
            w_err_nx   = 1'b0;
            w_state_nx = S_DONE;
            case (r_state)
                S_EMPTY: w_value_nx = 8'sd0;
                S_ENTRY: w_value_nx = apply_sign(r_mag, r_neg);
                default: w_value_nx = r_value;
            endcase
        end else if (r_neg_p1) begin
            case (r_state)
                S_ENTRY: begin
                    if (r_neg && (r_mag == 8'd128)) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_neg_nx = ~r_neg;
                        w_err_nx = 1'b0;
                    end
                end
                S_DONE: begin
                    w_mag_nx   = 8'd0;
                    w_neg_nx   = 1'b1;
                    w_ndig_nx  = 2'd0;
                    w_err_nx   = 1'b0;
                    w_state_nx = S_EMPTY;
                end
                default: begin
                    w_neg_nx = ~r_neg;
                    w_err_nx = 1'b0;
                end
            endcase
        end else if (r_digv_p1) begin
            if (r_dig_p1 > 4'd9) begin
                w_err_nx = 1'b1;
            end else begin
                case (r_state)
                    S_ENTRY: begin
                        if ((r_ndig < 2'd3) && (w_mag_new <= w_mag_lim)) begin
                            w_mag_nx  = w_mag_new[7:0];
                            w_ndig_nx = r_ndig + 2'd1;
                            w_err_nx  = 1'b0;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end
                    S_DONE: begin
                        w_mag_nx   = {4'd0, r_dig_p1};
                        w_neg_nx   = 1'b0;
                        w_ndig_nx  = 2'd1;
                        w_err_nx   = 1'b0;
                        w_state_nx = S_ENTRY;
                    end
                    default: begin
                        w_mag_nx   = {4'd0, r_dig_p1};
                        w_ndig_nx  = 2'd1;
                        w_err_nx   = 1'b0;
                        w_state_nx = S_ENTRY;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.BCD_O       = to_bcd(r_mag, r_neg);
        bus.value       = r_value;
        bus.value_valid = r_vld_p2;
        bus.err         = r_err;
    end
endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit; commits are checked by a scoreboard monitor on value_valid.
module tb_input_unit;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    input_unit_if bus();
    input_unit dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [7:0] val;
        int         at;
    } exp_t;
    exp_t q[$];
    exp_t m_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] bcd, input logic err);
        chk({name, "_bcd"}, {16'd0, bus.BCD_O}, {16'd0, bcd});
        chk({name, "_err"}, {31'd0, bus.err}, {31'd0, err});
    endtask

    // scoreboard monitor: every valid pulse must match the oldest expected commit
    always @(negedge clk) begin
        if (bus.value_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: value_valid=1 value=%0h at cycle %0d, expected no pulse",
                         bus.value, cyc);
            end else begin
                m_e = q.pop_front();
                chk("commit_value", {24'd0, bus.value}, {24'd0, m_e.val});
                chk("commit_cycle", cyc, m_e.at);
            end
        end
    end

    // keys = {clear, enter, neg, press}; returns after the outputs have settled
    task automatic press(input logic [3:0] keys, input logic [3:0] d, input int hold,
                         input logic [7:0] commit);
        exp_t e;
        @(negedge clk);
        bus.key_clear = keys[3];
        bus.key_enter = keys[2];
        bus.key_neg   = keys[1];
        bus.key_press = keys[0];
        bus.key_digit = d;
        if (keys[2] && !keys[3]) begin
            e.val = commit;
            e.at  = cyc + 3;
            q.push_back(e);
        end
        repeat (hold) @(negedge clk);
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        bus.key_neg   = 1'b0;
        bus.key_press = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic dig(input logic [3:0] d);  press(4'b0001, d, 1, 8'h00); endtask
    task automatic sgn();                     press(4'b0010, 4'd0, 1, 8'h00); endtask
    task automatic clr();                     press(4'b1000, 4'd0, 1, 8'h00); endtask
    task automatic ent(input logic [7:0] v);  press(4'b0100, 4'd0, 1, v); endtask

    initial begin
        bus.key_clear = 1'b0;
        bus.key_enter = 1'b0;
        bus.key_neg   = 1'b0;
        bus.key_press = 1'b0;
        bus.key_digit = 4'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", 16'hF000, 1'b0);
        chk("reset_value", {24'd0, bus.value}, 32'h0);
        chk("reset_valid", {31'd0, bus.value_valid}, 32'h0);
        reset = 1'b0;

        dig(4'd1); chk_out("d1", 16'hF001, 1'b0);
        dig(4'd2); chk_out("d12", 16'hF012, 1'b0);
        dig(4'd3); chk_out("d123", 16'hF123, 1'b0);
        ent(8'd123);
        chk("v123", {24'd0, bus.value}, 32'h7B);
        chk_out("e123", 16'hF123, 1'b0);

        clr();
        sgn();     chk_out("neg_empty", 16'hF000, 1'b0);
        dig(4'd1); chk_out("m1", 16'hA001, 1'b0);
        dig(4'd2);
        dig(4'd8); chk_out("m128", 16'hA128, 1'b0);
        sgn();     chk_out("neg_rej", 16'hA128, 1'b1);
        ent(8'h80);
        chk("vm128", {24'd0, bus.value}, 32'h80);
        chk_out("em128", 16'hA128, 1'b0);

        sgn();     chk_out("neg_done", 16'hF000, 1'b0);
        ent(8'h00);
        chk("vnegzero", {24'd0, bus.value}, 32'h00);
        chk_out("enegzero", 16'hF000, 1'b0);
        dig(4'd4); chk_out("done_d4", 16'hF004, 1'b0);
        ent(8'h04);
        chk("v4", {24'd0, bus.value}, 32'h04);

        clr();
        dig(4'd1);
        dig(4'd3); chk_out("d13", 16'hF013, 1'b0);
        dig(4'd0); chk_out("d130_rej", 16'hF013, 1'b1);
        dig(4'd5); chk_out("d135_rej", 16'hF013, 1'b1);
        sgn();     chk_out("neg_ok_clears_err", 16'hA013, 1'b0);
        dig(4'hC); chk_out("bad_code", 16'hA013, 1'b1);

        press(4'b1100, 4'd0, 1, 8'h00);
        chk_out("clr_ent", 16'hF000, 1'b0);
        chk("clr_ent_value", {24'd0, bus.value}, 32'h04);

        clr();
        dig(4'd1);
        dig(4'd2);
        dig(4'd8); chk_out("p128_rej", 16'hF012, 1'b1);
        dig(4'd7); chk_out("p127", 16'hF127, 1'b0);
        dig(4'd1); chk_out("ndig_rej", 16'hF127, 1'b1);

        clr();
        dig(4'd9);
        press(4'b0100, 4'd0, 5, 8'h09);
        chk("held_enter", {24'd0, bus.value}, 32'h09);
        ent(8'h09);

        clr();
        dig(4'd4);
        dig(4'd2); chk_out("d42", 16'hF042, 1'b0);
        dig(4'hF); chk_out("pre_reset_err", 16'hF042, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk_out("mid_reset", 16'hF000, 1'b0);
        chk("mid_reset_value", {24'd0, bus.value}, 32'h00);
        chk("mid_reset_valid", {31'd0, bus.value_valid}, 32'h0);

        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_valid: %0d commits pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
